// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC sequencer: sequential advance, D-stage redirects, stall handling
// with one buffered redirect, and instruction-memory window checking with sticky fault.
module fetch_pc_ctrl #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int unsigned IM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        fault_clr,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic        fd_we,
    output logic        fault,
    output logic [31:0] fault_pc
);

    localparam int unsigned ADDR_W = 32;
    localparam logic [ADDR_W:0] IM_LO = (ADDR_W+1)'(IM_BASE);
    localparam logic [ADDR_W:0] IM_HI = (ADDR_W+1)'(IM_BASE) + (ADDR_W+1)'(IM_WORDS) * (ADDR_W+1)'(4);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PEND  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pend_pc, pend_nxt;
    logic [ADDR_W-1:0] pc_nxt, fault_pc_nxt;
    logic [ADDR_W-1:0] cand;
    logic              cand_legal;

    // Window compare is done in 33 bits so the upper bound cannot wrap.
    always_comb begin
        cand = pc + 32'd4;
        if (redirect) begin
            cand = redirect_pc;
        end else if (state == ST_PEND) begin
            cand = pend_pc;
        end
        cand_legal = (cand[1:0] == 2'b00)
                  && ({1'b0, cand} >= IM_LO)
                  && ({1'b0, cand} <  IM_HI);
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        pend_nxt     = pend_pc;
        fault_pc_nxt = fault_pc;
        case (state)
            ST_RUN, ST_PEND: begin
                if (stall) begin
                    if (redirect) begin
                        pend_nxt  = redirect_pc;
                        state_nxt = ST_PEND;
                    end
                end else if (cand_legal) begin
                    pc_nxt    = cand;
                    state_nxt = ST_RUN;
                end else begin
                    fault_pc_nxt = cand;
                    state_nxt    = ST_FAULT;
                end
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    pc_nxt    = PC_RESET;
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_RUN;
            pc       <= PC_RESET;
            pend_pc  <= '0;
            fault_pc <= '0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            pend_pc  <= pend_nxt;
            fault_pc <= fault_pc_nxt;
        end
    end

    assign pc_valid = (state != ST_FAULT);
    assign fd_we    = !stall && (state != ST_FAULT);
    assign fault    = (state == ST_FAULT);

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl: per-cycle compare against a behavioural
// model plus literal expectations along the stimulus sequence.
module tb_fetch_pc_ctrl;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] IM_BASE  = 32'h0000_3000;
    localparam int unsigned IM_WORDS = 4096;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        fault_clr = 1'b0;
    logic [31:0] pc;
    logic        pc_valid;
    logic        fd_we;
    logic        fault;
    logic [31:0] fault_pc;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_pc_ctrl #(.PC_RESET(PC_RESET), .IM_BASE(IM_BASE), .IM_WORDS(IM_WORDS)) dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .fault_clr(fault_clr), .pc(pc),
        .pc_valid(pc_valid), .fd_we(fd_we), .fault(fault), .fault_pc(fault_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a fetch address, an optional pending target, a fault flag.
    logic [31:0] m_pc = 32'h0, m_pend = 32'h0, m_fault_pc = 32'h0;
    bit          m_pend_valid = 1'b0, m_fault = 1'b0;

    function automatic bit legal(input logic [31:0] a);
        longint unsigned v = longint'(a);
        longint unsigned lo = longint'(IM_BASE);
        return (a % 4 == 0) && (v >= lo) && (v < lo + 4 * longint'(IM_WORDS));
    endfunction

    always @(posedge clk or negedge reset) begin
        logic [31:0] tgt;
        if (!reset) begin
            m_pc = PC_RESET; m_pend_valid = 1'b0; m_fault = 1'b0; m_fault_pc = 32'h0;
        end else if (m_fault) begin
            if (fault_clr) begin
                m_pc = PC_RESET; m_fault = 1'b0;
            end
        end else if (stall) begin
            if (redirect) begin
                m_pend = redirect_pc; m_pend_valid = 1'b1;
            end
        end else begin
            tgt = redirect ? redirect_pc : (m_pend_valid ? m_pend : m_pc + 32'd4);
            m_pend_valid = 1'b0;
            if (legal(tgt)) m_pc = tgt;
            else begin
                m_fault = 1'b1; m_fault_pc = tgt;
            end
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        chk("pc", pc, m_pc);
        chk("pc_valid", 32'(pc_valid), 32'(!m_fault));
        chk("fd_we", 32'(fd_we), 32'(!stall && !m_fault));
        chk("fault", 32'(fault), 32'(m_fault));
        chk("fault_pc", fault_pc, m_fault_pc);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redir(input logic [31:0] a);
        redirect = 1'b1; redirect_pc = a;
        tick();
        redirect = 1'b0;
    endtask

    task automatic clear_fault();
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("clr_pc", pc, 32'h3000);
        chk("clr_fault", 32'(fault), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_pc", pc, 32'h3000);
        chk("rst_fault_pc", fault_pc, 32'h0);
        reset = 1'b1;
        // Sequential advance
        tick(); chk("seq1", pc, 32'h3004);
        tick(); chk("seq2", pc, 32'h3008);
        tick(); chk("seq3", pc, 32'h300C);
        chk("seq_fd_we", 32'(fd_we), 32'h1);
        tick(); chk("seq4", pc, 32'h3010);
        // Unstalled redirect lands next cycle
        redir(32'h3400); chk("redir", pc, 32'h3400);
        tick(); chk("redir_seq", pc, 32'h3404);
        redir(32'h301C);
        tick(); chk("pre_stall", pc, 32'h3020);
        // Redirect during stall is buffered
        stall = 1'b1;
        redir(32'h3100);
        chk("stall_hold", pc, 32'h3020);
        chk("stall_fd_we", 32'(fd_we), 32'h0);
        tick(); tick(); chk("stall_hold3", pc, 32'h3020);
        stall = 1'b0;
        tick(); chk("pend_release", pc, 32'h3100);
        // Latest buffered redirect wins
        stall = 1'b1;
        redir(32'h3100);
        redir(32'h3200);
        stall = 1'b0;
        tick(); chk("pend_latest", pc, 32'h3200);
        // Same-cycle redirect beats buffered one
        stall = 1'b1;
        redir(32'h3100);
        tick();
        stall = 1'b0;
        redir(32'h3300); chk("pend_override", pc, 32'h3300);
        // Below-window fault; frozen under later activity
        redir(32'h2FFC);
        chk("lo_fault", 32'(fault), 32'h1);
        chk("lo_fault_pc", fault_pc, 32'h2FFC);
        chk("lo_pc_valid", 32'(pc_valid), 32'h0);
        chk("lo_fd_we", 32'(fd_we), 32'h0);
        redir(32'h3500); chk("lo_frozen", pc, 32'h3300);
        stall = 1'b1; redir(32'h3600); stall = 1'b0;
        chk("lo_frozen2", pc, 32'h3300);
        clear_fault();
        // fault_clr outside FAULT has no effect
        fault_clr = 1'b1; tick(); fault_clr = 1'b0;
        chk("clr_ignored", pc, 32'h3004);
        // Misaligned target
        redir(32'h3002);
        chk("mis_fault_pc", fault_pc, 32'h3002);
        chk("mis_fault", 32'(fault), 32'h1);
        clear_fault();
        chk("keep_fault_pc", fault_pc, 32'h3002);
        // Sequential run off the top of the window
        redir(32'h6FF4);
        tick(); tick(); chk("top_last", pc, 32'h6FFC);
        tick();
        chk("top_fault_pc", fault_pc, 32'h7000);
        chk("top_pc", pc, 32'h6FFC);
        clear_fault();
        // Async reset mid-PEND discards the buffered target
        stall = 1'b1;
        redir(32'h3100);
        #2 reset = 1'b0;
        #1 chk("async_pc", pc, 32'h3000);
        chk("async_fault", 32'(fault), 32'h0);
        stall = 1'b0;
        @(negedge clk); reset = 1'b1;
        tick(); chk("pend_discarded", pc, 32'h3004);
        tick(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
Sequencer for the instruction-fetch stage. It owns the fetch PC and drives the PC field that the instruction-memory fetch reads. It applies sequential advance, branch/jump redirects resolved in D, and hazard-unit stalls, and buffers a redirect that arrives while fetch is stalled. It also range- and alignment-checks every new PC against the instruction memory window and halts fetch on a violation.

Parameters:
PC_RESET, 32'h0000_3000, PC value loaded on reset and on fault clear.
IM_BASE, 32'h0000_3000, byte address of instruction-memory word 0.
IM_WORDS, 4096, instruction-memory depth in 32-bit words; legal window is [IM_BASE, IM_BASE+4*IM_WORDS).

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset; low forces reset state immediately.
stall  input  1  hazard-unit stall; 1 = hold PC and F/D register this cycle.
redirect  input  1  one-cycle pulse from D: taken branch/jump resolved.
redirect_pc  input  32  target PC, valid when redirect=1.
fault_clr  input  1  one-cycle pulse; leaves FAULT and restarts fetch.
pc  output  32  current fetch PC, feeds the fetch stage PC field.
pc_valid  output  1  1 = instruction fetched at pc is real; 0 in FAULT.
fd_we  output  1  F/D pipeline register write enable.
fault  output  1  sticky; 1 while in FAULT.
fault_pc  output  32  offending PC captured on fault entry.

Behaviour:
- Reset (reset=0, async): pc=PC_RESET; state=RUN; pend_pc=0; fault=0; fault_pc=0; pc_valid=1; fd_we=!stall.
- States: RUN, PEND (stalled with buffered redirect), FAULT.
- nxt = candidate next PC, computed mod 2^32 with no carry out. Legal iff nxt[1:0]==0 and IM_BASE <= nxt < IM_BASE+4*IM_WORDS. The comparison uses a 33-bit or otherwise overflow-safe computation.
- RUN, stall=0: nxt = redirect ? redirect_pc : pc+4. If legal: pc<=nxt, stay RUN. If illegal: pc holds, fault_pc<=nxt, state<=FAULT.
- RUN, stall=1: pc holds. If redirect: pend_pc<=redirect_pc, state<=PEND. Else stay RUN.
- PEND, stall=1: pc holds. A new redirect overwrites pend_pc (latest wins).
- PEND, stall=0: nxt = redirect ? redirect_pc : pend_pc, so a same-cycle redirect beats the buffered one. Legal: pc<=nxt, state<=RUN. Illegal: enter FAULT as in RUN.
- pc+4 is never used when leaving PEND. The buffered target always replaces sequential advance.
- FAULT: pc, fault_pc and pend_pc are frozen; stall and redirect are ignored.
- Leaving FAULT: fault_clr=1 gives pc<=PC_RESET, state<=RUN, fault<=0. fault_pc keeps its last value until the next fault or reset.
- fault_clr outside FAULT is ignored.
- Outputs are combinational from state: pc_valid = (state!=FAULT); fd_we = !stall && state!=FAULT; fault = (state==FAULT).
- Latency: a redirect asserted in cycle N with stall=0 appears on pc in cycle N+1. The instruction fetched in cycle N (the delay slot) is not squashed.
- Wrap-around: pc+4 past 32'hFFFF_FFFC gives 0, which is out of the window, so it faults.
- PC_RESET is not checked; it is required to be inside the window.
- Reset in any state, including mid-PEND, discards the buffered target.

Test Plan:
- Release reset with stall=0 for 3 cycles -> pc = 0x3000, 0x3004, 0x3008, 0x300C; pc_valid=1; fd_we=1.
- At pc=0x3010, redirect=1 with redirect_pc=0x3400 and stall=0 -> next cycle pc=0x3400, then 0x3404.
- At pc=0x3020, raise stall for 3 cycles and pulse redirect (0x3100) in the first of them -> pc holds 0x3020 and fd_we=0 during the stall. The cycle after stall drops, pc=0x3100 (not 0x3024).
- Within one stall window, pulse redirect 0x3100 then 0x3200 -> after unstall pc=0x3200. Repeat with a redirect to 0x3300 in the unstall cycle -> pc=0x3300.
- Redirect to 0x2FFC -> FAULT: fault=1, fault_pc=0x2FFC, pc_valid=0, fd_we=0, and pc frozen under later redirects. Repeat with misaligned 0x3002 and with sequential run to 0x6FFC then +4=0x7000 -> fault_pc=0x7000. Pulse fault_clr -> pc=0x3000, fault=0.
- Assert reset low mid-clock while in PEND -> pc=0x3000 and fault=0 immediately. After release with no redirect, pc advances to 0x3004, confirming the buffered target was discarded.
